// File: rtl/clint_dbus_responder.sv
// -----------------------------------------------------------------------------
// clint_dbus_responder
//
// Core-local interruptor (CLINT) on the responder side of the data-bus
// request/response protocol. It serves loads and stores to msip, mtimecmp and
// mtime inside a 64 KiB window at BASE_ADDR. It also drives the core's timer
// interrupt (trint) and software interrupt (swint).
//
// Parameters:
//   BASE_ADDR : base address of the 64 KiB CLINT window
//   LATENCY   : cycles from the accept cycle to data_ok (1..15)
//   TICK_DIV  : mtime advances once every TICK_DIV clk cycles (1..65535)
//
// Ports:
//   clk      : clock
//   reset    : synchronous, active-high reset
//   dbg_halt : (only with CLINT_DEBUG_FREEZE_EN) freezes the divider and mtime
//   dreq     : bus request  {valid, addr, size, strobe, data}
//   dresp    : bus response {addr_ok, data_ok, data}
//   trint    : timer interrupt pending (mtime >= mtimecmp)
//   swint    : software interrupt pending (msip[0])
//
// Optional feature macro: CLINT_DEBUG_FREEZE_EN
//   When defined, the dbg_halt input is added. While dbg_halt is high, the tick
//   divider and mtime hold their values. Bus writes to mtime still take effect.
// -----------------------------------------------------------------------------

package clint_dbus_pkg;
  typedef logic [2:0] msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module clint_dbus_responder
  import clint_dbus_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic       clk,
  input  logic       reset,
`ifdef CLINT_DEBUG_FREEZE_EN
  input  logic       dbg_halt,
`endif
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       trint,
  output logic       swint
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Register word indices (byte offset >> 3) inside the window.
  localparam logic [12:0] WORD_MSIP     = 13'h0000;  // 0x0000
  localparam logic [12:0] WORD_MTIMECMP = 13'h0800;  // 0x4000
  localparam logic [12:0] WORD_MTIME    = 13'h17FF;  // 0xBFF8

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        accept;

  logic [63:0] addr_reg;
  logic [7:0]  strobe_reg;
  logic [63:0] wdata_reg;

  logic        msip_reg, msip_next;
  logic [63:0] mtime_reg, mtime_next;
  logic [63:0] mtimecmp_reg, mtimecmp_next;
  logic [15:0] div_reg, div_next;
  logic        trint_reg, swint_reg;
  logic [63:0] rdata_hold_reg;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dreq.valid) begin
          accept     = 1'b1;
          cnt_next   = 4'(LATENCY - 1);
          state_next = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        // The counter reaches zero on this edge, so RESP lands exactly
        // LATENCY cycles after the accept cycle.
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address decode on the latched request
  // ---------------------------------------------------------------------------
  logic [63:0] off;
  logic        in_window;
  logic [12:0] word;
  logic        sel_msip, sel_mtimecmp, sel_mtime;
  logic        is_resp, do_write;
  logic [63:0] read_val;

  // Addresses below BASE_ADDR wrap to a huge offset, so they fail the window
  // test as well.
  assign off          = addr_reg - BASE_ADDR;
  assign in_window    = (off[63:16] == 48'd0);
  assign word         = off[15:3];
  assign sel_msip     = in_window && (word == WORD_MSIP);
  assign sel_mtimecmp = in_window && (word == WORD_MTIMECMP);
  assign sel_mtime    = in_window && (word == WORD_MTIME);

  assign is_resp  = (state_reg == RESP);
  assign do_write = is_resp && (strobe_reg != 8'd0);

  always_comb begin
    read_val = 64'd0;
    if (sel_msip) begin
      read_val = {63'd0, msip_reg};
    end else if (sel_mtimecmp) begin
      read_val = mtimecmp_reg;
    end else if (sel_mtime) begin
      read_val = mtime_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte-lane write merge (lanes follow the full 64-bit bus)
  // ---------------------------------------------------------------------------
  logic [63:0] wmask;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_wmask
      assign wmask[8*gi +: 8] = {8{strobe_reg[gi]}};
    end
  endgenerate

  logic [63:0] merged_mtime, merged_mtimecmp;
  assign merged_mtime    = (mtime_reg    & ~wmask) | (wdata_reg & wmask);
  assign merged_mtimecmp = (mtimecmp_reg & ~wmask) | (wdata_reg & wmask);

  // ---------------------------------------------------------------------------
  // Timebase
  // ---------------------------------------------------------------------------
  logic halt;
  logic tick;

`ifdef CLINT_DEBUG_FREEZE_EN
  assign halt = dbg_halt;
`else
  assign halt = 1'b0;
`endif

  assign tick = !halt && (div_reg == 16'(TICK_DIV - 1));

  always_comb begin
    div_next = div_reg;
    if (!halt) begin
      div_next = tick ? 16'd0 : div_reg + 16'd1;
    end
  end

  // A bus write to mtime overrides a coincident tick. The divider keeps running.
  always_comb begin
    mtime_next = mtime_reg;
    if (do_write && sel_mtime) begin
      mtime_next = merged_mtime;
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_next = mtimecmp_reg;
    if (do_write && sel_mtimecmp) begin
      mtimecmp_next = merged_mtimecmp;
    end
  end

  always_comb begin
    msip_next = msip_reg;
    if (do_write && sel_msip && strobe_reg[0]) begin
      msip_next = wdata_reg[0];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      addr_reg       <= 64'd0;
      strobe_reg     <= 8'd0;
      wdata_reg      <= 64'd0;
      msip_reg       <= 1'b0;
      mtime_reg      <= 64'd0;
      mtimecmp_reg   <= 64'hFFFF_FFFF_FFFF_FFFF;
      div_reg        <= 16'd0;
      trint_reg      <= 1'b0;
      swint_reg      <= 1'b0;
      rdata_hold_reg <= 64'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg   <= dreq.addr;
        strobe_reg <= dreq.strobe;
        wdata_reg  <= dreq.data;
      end
      msip_reg     <= msip_next;
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      div_reg      <= div_next;
      // Compare on the next-state values so the interrupt lines move on the
      // same edge as the registers that drive them.
      trint_reg    <= (mtime_next >= mtimecmp_next);
      swint_reg    <= msip_next;
      if (is_resp) begin
        rdata_hold_reg <= read_val;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Response data is live during RESP. Otherwise the last response is held.
  assign dresp.addr_ok = accept;
  assign dresp.data_ok = is_resp;
  assign dresp.data    = is_resp ? read_val : rdata_hold_reg;
  assign trint         = trint_reg;
  assign swint         = swint_reg;

  // The transfer size is not needed because byte lanes come from the strobe,
  // and the word decode ignores the low offset bits.
  logic unused_bits;
  assign unused_bits = ^{dreq.size, off[2:0]};

endmodule

// File: tb/tb_clint_dbus_responder.sv
// -----------------------------------------------------------------------------
// tb_clint_dbus_responder
//
// Directed testbench for clint_dbus_responder. Two instances are used:
//   dut1 : LATENCY=1, TICK_DIV=1 (mtime equals cycles since reset release)
//   dut4 : LATENCY=4, TICK_DIV=3
// -----------------------------------------------------------------------------
module tb_clint_dbus_responder;
  import clint_dbus_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  dbus_req_t  req1, req4;
  dbus_resp_t resp1, resp4;
  logic       trint1, swint1, trint4, swint4;
`ifdef CLINT_DEBUG_FREEZE_EN
  logic       dbg_halt = 1'b0;
  logic       halt4 = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc1   = 0;   // cycles since dut1 reset release == expected dut1 mtime

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst1) cyc1 <= 0;
    else      cyc1 <= cyc1 + 1;
  end

  clint_dbus_responder #(.BASE_ADDR(BASE), .LATENCY(1), .TICK_DIV(1)) dut1 (
    .clk(clk),
    .reset(rst1),
`ifdef CLINT_DEBUG_FREEZE_EN
    .dbg_halt(dbg_halt),
`endif
    .dreq(req1),
    .dresp(resp1),
    .trint(trint1),
    .swint(swint1)
  );

  clint_dbus_responder #(.BASE_ADDR(BASE), .LATENCY(4), .TICK_DIV(3)) dut4 (
    .clk(clk),
    .reset(rst4),
`ifdef CLINT_DEBUG_FREEZE_EN
    .dbg_halt(halt4),
`endif
    .dreq(req4),
    .dresp(resp4),
    .trint(trint4),
    .swint(swint4)
  );

  // One bus transaction. Checks addr_ok in the accept cycle and bounds the
  // wait for data_ok. It returns the read data, the latency in cycles and cyc1
  // in the data_ok cycle. It returns at the negedge of the data_ok cycle.
  task automatic bus_op(input bit use4, input string name, input logic [63:0] addr,
                        input logic [7:0] strb, input logic [63:0] wdata,
                        output logic [63:0] rdata, output int lat, output int at_cyc);
    dbus_req_t r;
    logic ok;
    r.valid  = 1'b1;
    r.addr   = addr;
    r.size   = 3'd3;
    r.strobe = strb;
    r.data   = wdata;
    @(negedge clk);
    if (use4) req4 = r; else req1 = r;
    #1;
    ok = use4 ? resp4.addr_ok : resp1.addr_ok;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s addr_ok: got %b want 1", name, ok);
    end
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      ok = use4 ? resp4.data_ok : resp1.data_ok;
    end while (ok !== 1'b1 && lat < 40);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s data_ok timeout: got %b want 1 within 40 cycles", name, ok);
    end
    rdata  = use4 ? resp4.data : resp1.data;
    at_cyc = cyc1;
    r.valid = 1'b0;
    if (use4) req4 = r; else req1 = r;
    $display("txn %-14s dut%0d addr=%h strb=%h wdata=%h rdata=%h lat=%0d",
             name, use4 ? 4 : 1, addr, strb, wdata, rdata, lat);
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    rst4 = 1'b1;
    req1 = '0;
    req4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp1 !== '0) begin
      errors++;
      $display("FAIL reset dresp1: got %h want 0", resp1);
    end
    checks++;
    if (resp4 !== '0) begin
      errors++;
      $display("FAIL reset dresp4: got %h want 0", resp4);
    end
    checks++;
    if ({trint1, swint1, trint4, swint4} !== 4'b0000) begin
      errors++;
      $display("FAIL reset irq: got %b want 0000", {trint1, swint1, trint4, swint4});
    end
    rst1 = 1'b0;
    rst4 = 1'b0;
  endtask

  task automatic test_read_mtime();
    logic [63:0] rd;
    int lat, at;
    bus_op(0, "read_mtime", BASE + 64'hBFF8, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL read_mtime latency: got %0d want 1", lat);
    end
    checks++;
    if (rd !== 64'(at)) begin
      errors++;
      $display("FAIL read_mtime data: got %h want %h", rd, 64'(at));
    end
    checks++;
    if ({trint1, swint1} !== 2'b00) begin
      errors++;
      $display("FAIL read_mtime irq: got %b want 00", {trint1, swint1});
    end
  endtask

  task automatic test_msip();
    logic [63:0] rd;
    int lat, at;
    bus_op(0, "msip_set", BASE, 8'h01, 64'h1, rd, lat, at);
    checks++;
    if (swint1 !== 1'b0) begin
      errors++;
      $display("FAIL msip_swint_early: got %b want 0", swint1);
    end
    @(negedge clk);
    checks++;
    if (swint1 !== 1'b1) begin
      errors++;
      $display("FAIL msip_swint_rise: got %b want 1", swint1);
    end
    bus_op(0, "msip_read", BASE, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (rd !== 64'h1) begin
      errors++;
      $display("FAIL msip_read: got %h want %h", rd, 64'h1);
    end
    bus_op(0, "msip_clear", BASE, 8'h01, 64'h0, rd, lat, at);
    @(negedge clk);
    checks++;
    if (swint1 !== 1'b0) begin
      errors++;
      $display("FAIL msip_swint_fall: got %b want 0", swint1);
    end
  endtask

  task automatic test_trint();
    logic [63:0] rd;
    int lat, at, n;
    bus_op(0, "cmp_write50", BASE + 64'h4000, 8'hFF, 64'd50, rd, lat, at);
    n = 0;
    while (trint1 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc1 != 50 || trint1 !== 1'b1) begin
      errors++;
      $display("FAIL trint_rise: got trint=%b at mtime=%0d want trint=1 at mtime=50", trint1, cyc1);
    end
    bus_op(0, "cmp_write_max", BASE + 64'h4000, 8'hFF, ONES, rd, lat, at);
    checks++;
    if (trint1 !== 1'b1) begin
      errors++;
      $display("FAIL trint_hold: got %b want 1", trint1);
    end
    @(negedge clk);
    checks++;
    if (trint1 !== 1'b0) begin
      errors++;
      $display("FAIL trint_fall: got %b want 0", trint1);
    end
  endtask

  task automatic test_byte_merge();
    logic [63:0] rd;
    int lat, at;
    bus_op(0, "cmp_full", BASE + 64'h4000, 8'hFF, 64'h1122_3344_5566_7788, rd, lat, at);
    bus_op(0, "cmp_merge", BASE + 64'h4000, 8'h81, 64'hAA00_0000_0000_00BB, rd, lat, at);
    bus_op(0, "cmp_read", BASE + 64'h4000, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (rd !== 64'hAA22_3344_5566_77BB) begin
      errors++;
      $display("FAIL byte_merge: got %h want %h", rd, 64'hAA22_3344_5566_77BB);
    end
  endtask

  task automatic test_mtime_write();
    logic [63:0] rd;
    int lat, at;
    // Commit at the end of RESP. The next read lands two cycles later.
    bus_op(0, "mtime_w1000", BASE + 64'hBFF8, 8'hFF, 64'd1000, rd, lat, at);
    bus_op(0, "mtime_read", BASE + 64'hBFF8, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (rd !== 64'd1001) begin
      errors++;
      $display("FAIL mtime_write: got %h want %h", rd, 64'd1001);
    end
  endtask

  task automatic test_latency4();
    logic [63:0] rd;
    int lat, at;
    bus_op(1, "cmp_read4", BASE + 64'h4000, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL latency4: got %0d want 4", lat);
    end
    checks++;
    if (rd !== ONES) begin
      errors++;
      $display("FAIL latency4 data: got %h want %h", rd, ONES);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd;
    int lat, at, seen;
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = BASE + 64'h4000;
    r.size   = 3'd3;
    r.strobe = 8'hFF;
    r.data   = 64'h1234;
    @(negedge clk);
    req4 = r;                          // accepted in this cycle (t)
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);                  // cycle t+i
      if (resp4.data_ok === 1'b1) seen++;
      if (i == 2) rst4 = 1'b1;         // reset sampled at the end of t+2
      if (i == 3) begin
        rst4 = 1'b0;
        req4.valid = 1'b0;
      end
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid data_ok: got %0d pulses want 0", seen);
    end
    bus_op(1, "cmp_after_rst", BASE + 64'h4000, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (rd !== ONES) begin
      errors++;
      $display("FAIL reset_mid write dropped: got %h want %h", rd, ONES);
    end
  endtask

  task automatic test_unmapped();
    logic [63:0] rd;
    int lat, at;
    bus_op(1, "unmapped_w", BASE + 64'h8000, 8'hFF, ONES, rd, lat, at);
    bus_op(1, "unmapped_r", BASE + 64'h8000, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (rd !== 64'd0 || lat != 4) begin
      errors++;
      $display("FAIL unmapped read: got data=%h lat=%0d want data=0 lat=4", rd, lat);
    end
    // Just past the window: these offsets would alias msip / mtimecmp.
    bus_op(1, "outside_msip", BASE + 64'h1_0000, 8'h01, 64'h1, rd, lat, at);
    bus_op(1, "outside_cmp", BASE + 64'h1_4000, 8'hFF, 64'd0, rd, lat, at);
    bus_op(1, "below_base", BASE - 64'd8, 8'hFF, ONES, rd, lat, at);
    bus_op(1, "msip_read4", BASE, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (rd !== 64'd0 || swint4 !== 1'b0) begin
      errors++;
      $display("FAIL outside window msip: got data=%h swint=%b want 0/0", rd, swint4);
    end
    bus_op(1, "cmp_read4b", BASE + 64'h4000, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (rd !== ONES) begin
      errors++;
      $display("FAIL outside window cmp: got %h want %h", rd, ONES);
    end
  endtask

  task automatic test_tick_div();
    logic [63:0] a, b;
    int lat, at;
    // Two mtime reads whose data_ok cycles are exactly 15 cycles apart.
    bus_op(1, "mtime_div_a", BASE + 64'hBFF8, 8'h00, 64'd0, a, lat, at);
    repeat (10) @(negedge clk);
    bus_op(1, "mtime_div_b", BASE + 64'hBFF8, 8'h00, 64'd0, b, lat, at);
    checks++;
    if (b - a !== 64'd5) begin
      errors++;
      $display("FAIL tick_div delta: got %0d want 5", b - a);
    end
  endtask

`ifdef CLINT_DEBUG_FREEZE_EN
  task automatic test_freeze();
    logic [63:0] rd;
    int lat, at;
    @(negedge clk);
    dbg_halt = 1'b1;
    bus_op(0, "frz_w100", BASE + 64'hBFF8, 8'hFF, 64'd100, rd, lat, at);
    repeat (20) @(negedge clk);
    bus_op(0, "frz_read", BASE + 64'hBFF8, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (rd !== 64'd100) begin
      errors++;
      $display("FAIL freeze hold: got %h want %h", rd, 64'd100);
    end
    dbg_halt = 1'b0;
    bus_op(0, "frz_resume", BASE + 64'hBFF8, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (rd !== 64'd102) begin
      errors++;
      $display("FAIL freeze resume: got %h want %h", rd, 64'd102);
    end
    bus_op(0, "mtime_wmax", BASE + 64'hBFF8, 8'hFF, ONES, rd, lat, at);
    bus_op(0, "mtime_wrap", BASE + 64'hBFF8, 8'h00, 64'd0, rd, lat, at);
    checks++;
    if (rd !== 64'd0) begin
      errors++;
      $display("FAIL mtime wrap: got %h want 0", rd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_mtime();
    test_msip();
    test_trint();
    test_byte_merge();
    test_mtime_write();
    test_latency4();
    test_reset_mid();
    test_unmapped();
    test_tick_div();
`ifdef CLINT_DEBUG_FREEZE_EN
    test_freeze();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
